// File: rtl/register.sv
// Parameterised N-bit D-type register with synchronous active-high reset and
// load enable. Q comes straight from the storage flops.
module register #(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  logic [N-1:0] q_r;

  // Storage flops: reset wins over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RST_VAL;
    end else if (en) begin
      q_r <= D;
    end else begin
      q_r <= q_r;
    end
  end

  assign Q = q_r;

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for register: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one step after each rising edge.
module tb_register;

  typedef struct {
    int         cyc;
    int         inst;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, en8;
  logic [7:0] d8, q8;
  logic       rst5, en5;
  logic [4:0] d5, q5;
  logic       rst7, en7;
  logic [4:0] d7, q7;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  register #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .D(d8), .Q(q8)
  );

  register #(.N(5), .RST_VAL(5'd0)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .D(d5), .Q(q5)
  );

  register #(.N(5), .RST_VAL(5'd7)) dut7 (
    .clk(clk), .rst(rst7), .en(en7), .D(d7), .Q(q7)
  );

  // Counter feedback for the 5-bit instance: 0..18 then wrap to 2.
  always_comb d5 = (q5 == 5'd18) ? 5'd2 : q5 + 5'd1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] exp, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.inst = inst;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step8(input logic r, input logic e, input logic [7:0] d,
                       input logic [7:0] exp, input string name);
    @(negedge clk);
    rst8 = r;
    en8  = e;
    d8   = d;
    push(0, exp, name);
  endtask

  // Monitor: compare every expectation due at the edge just taken.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.inst)
          0:       act = q8;
          1:       act = {3'b000, q5};
          2:       act = {3'b000, q7};
          default: act = 8'hxx;
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    rst8 = 1'b1; en8 = 1'b0; d8 = 8'h00;
    rst5 = 1'b1; en5 = 1'b1;
    rst7 = 1'b1; en7 = 1'b0; d7 = 5'd0;

    // Reset, with en high and data present
    step8(1'b1, 1'b1, 8'hA5, 8'h00, "rst_en_hi");
    step8(1'b1, 1'b1, 8'h5A, 8'h00, "rst_hold1");
    step8(1'b1, 1'b0, 8'hFF, 8'h00, "rst_hold2");
    step8(1'b1, 1'b0, 8'hFF, 8'h00, "rst_hold3");

    // Load
    step8(1'b0, 1'b1, 8'h3C, 8'h3C, "load_3c");
    step8(1'b0, 1'b1, 8'hFF, 8'hFF, "load_ff");

    // Hold
    step8(1'b0, 1'b0, 8'h12, 8'hFF, "hold1");
    step8(1'b0, 1'b0, 8'h12, 8'hFF, "hold2");
    step8(1'b0, 1'b0, 8'h12, 8'hFF, "hold3");
    step8(1'b0, 1'b1, 8'h12, 8'h12, "load_12");

    // Reset raised and released mid-cycle
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b0; d8 = 8'h12;
    #1 check("rst_mid_no_async", q8, 8'h12);
    push(0, 8'h00, "rst_sync");
    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h55;
    #1 check("rst_release_mid", q8, 8'h00);
    push(0, 8'h55, "load_55");

    // Glitches between edges: only edge-time values count
    @(negedge clk);
    en8 = 1'b1; d8 = 8'hC3;
    #1 en8 = 1'b0; d8 = 8'h99;
    #1 check("glitch_no_comb", q8, 8'h55);
    en8 = 1'b0; d8 = 8'h77;
    push(0, 8'h55, "glitch_hold");
    @(negedge clk);
    en8 = 1'b0; d8 = 8'h00;
    #1 en8 = 1'b1; d8 = 8'hEE;
    #1 rst8 = 1'b1;
    #1 check("glitch_rst_pulse", q8, 8'h55);
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h66;
    push(0, 8'h66, "glitch_load");
    step8(1'b1, 1'b1, 8'h81, 8'h00, "rst_over_en");

    // 5-bit counter with 18->2 wrap, and RST_VAL=7 instance
    @(negedge clk);
    rst5 = 1'b1;
    rst7 = 1'b1; en7 = 1'b1; d7 = 5'd3;
    push(1, 8'd0, "n5_rst");
    push(2, 8'd7, "rv7_rst");
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      rst5 = 1'b0;
      m = (i <= 18) ? i : 2 + (i - 19);
      push(1, 8'(m), "n5_count");
      case (i)
        1: begin rst7 = 1'b0; en7 = 1'b0; d7 = 5'd9;  push(2, 8'd7,  "rv7_hold"); end
        2: begin rst7 = 1'b0; en7 = 1'b1; d7 = 5'd31; push(2, 8'd31, "rv7_load_max"); end
        3: begin rst7 = 1'b0; en7 = 1'b1; d7 = 5'd0;  push(2, 8'd0,  "rv7_load_zero"); end
        4: begin rst7 = 1'b1; en7 = 1'b0; d7 = 5'd5;  push(2, 8'd7,  "rv7_rerst"); end
        default: begin rst7 = 1'b1; en7 = 1'b0; d7 = 5'd0; end
      endcase
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
